// File: rtl/joy_nway_arbiter.sv
// Per-player 8-way joystick resolver: synchronise, debounce, optional 90-degree
// rotation, then resolve opposite-direction conflicts in last-wins, neutral or 4-way mode.
module joy_nway_arbiter #(
    parameter int unsigned NPLAYERS   = 2,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DEB_W      = 8
) (
    input  logic                    clk,
    input  logic                    I_RESETn,
    input  logic [4*NPLAYERS-1:0]   I_DIR,
    input  logic                    I_ROT,
    input  logic [1:0]              I_MODE,
    output logic [4*NPLAYERS-1:0]   O_DIR,
    output logic [NPLAYERS-1:0]     O_CHG
);

    localparam int unsigned NBITS    = 4 * NPLAYERS;
    localparam int unsigned DEB_EFF  = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
    localparam logic [DEB_W-1:0] CNT_TERM = DEB_W'(DEB_EFF - 1);

    localparam logic [1:0] MODE_LAST    = 2'b00;
    localparam logic [1:0] MODE_NEUTRAL = 2'b01;
    localparam logic [1:0] MODE_4WAY    = 2'b10;

    // last_axis encoding: 1 = vertical pair was pressed most recently
    localparam logic AXIS_H = 1'b0;
    localparam logic AXIS_V = 1'b1;

    // Bit positions inside a player nibble {U,D,L,R}
    localparam int unsigned BIT_R = 0;
    localparam int unsigned BIT_L = 1;
    localparam int unsigned BIT_D = 2;
    localparam int unsigned BIT_U = 3;

    logic [NBITS-1:0]            sync1;
    logic [NBITS-1:0]            sync2;
    logic [NBITS-1:0]            filt;
    logic [NBITS-1:0][DEB_W-1:0] cnt;
    logic [NBITS-1:0]            rot_c;
    logic [NBITS-1:0]            rot_prev;
    logic [NBITS-1:0]            res_c;
    logic [NPLAYERS-1:0]         chg_c;
    logic [1:0]                  mode_eff_c;

    // Two-flop synchroniser for the asynchronous direction inputs
    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= I_DIR;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: filtered bit follows sync2 only after DEB_EFF disagreeing cycles
    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            filt <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < int'(NBITS); i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= CNT_TERM) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        mode_eff_c = I_MODE;
        if (I_MODE == 2'b11) begin
            mode_eff_c = MODE_LAST;
        end
    end

    // Previous rotated value, used to detect new presses
    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            rot_prev <= '0;
        end else begin
            rot_prev <= rot_c;
        end
    end

    for (genvar p = 0; p < int'(NPLAYERS); p++) begin : g_player
        logic [3:0] f_d;
        logic [3:0] rot_d;
        logic [3:0] new_d;
        logic [3:0] res_d;
        logic [1:0] pair_h;
        logic [1:0] pair_v;
        logic [1:0] last_h;
        logic [1:0] last_v;
        logic [1:0] last_h_nxt;
        logic [1:0] last_v_nxt;
        logic       last_axis;
        logic       last_axis_nxt;

        assign f_d = filt[4*p +: 4];

        // Horizontal orientation maps L->U, R->D, D->L, U->R
        always_comb begin
            rot_d = f_d;
            if (I_ROT) begin
                rot_d[BIT_U] = f_d[BIT_L];
                rot_d[BIT_D] = f_d[BIT_R];
                rot_d[BIT_L] = f_d[BIT_D];
                rot_d[BIT_R] = f_d[BIT_U];
            end
        end

        assign rot_c[4*p +: 4] = rot_d;
        assign new_d           = rot_d & ~rot_prev[4*p +: 4];

        // Press history; L/U override R/D, and vertical overrides horizontal, on a tie
        always_comb begin
            last_h_nxt    = last_h;
            last_v_nxt    = last_v;
            last_axis_nxt = last_axis;
            if (new_d[BIT_R]) last_h_nxt = 2'b01;
            if (new_d[BIT_L]) last_h_nxt = 2'b10;
            if (new_d[BIT_D]) last_v_nxt = 2'b01;
            if (new_d[BIT_U]) last_v_nxt = 2'b10;
            if (new_d[BIT_L] || new_d[BIT_R]) last_axis_nxt = AXIS_H;
            if (new_d[BIT_U] || new_d[BIT_D]) last_axis_nxt = AXIS_V;
        end

        always_ff @(posedge clk or negedge I_RESETn) begin
            if (!I_RESETn) begin
                last_h    <= 2'b00;
                last_v    <= 2'b00;
                last_axis <= AXIS_V;
            end else begin
                last_h    <= last_h_nxt;
                last_v    <= last_v_nxt;
                last_axis <= last_axis_nxt;
            end
        end

        // Conflict resolution on the opposite-direction pairs
        always_comb begin
            pair_h = rot_d[1:0];
            pair_v = rot_d[3:2];
            if (&pair_h) begin
                pair_h = (mode_eff_c == MODE_NEUTRAL) ? 2'b00 : last_h_nxt;
            end
            if (&pair_v) begin
                pair_v = (mode_eff_c == MODE_NEUTRAL) ? 2'b00 : last_v_nxt;
            end
            if ((mode_eff_c == MODE_4WAY) && (|pair_h) && (|pair_v)) begin
                if (last_axis_nxt == AXIS_V) begin
                    pair_h = 2'b00;
                end else begin
                    pair_v = 2'b00;
                end
            end
            res_d = {pair_v, pair_h};
        end

        assign res_c[4*p +: 4] = res_d;
        assign chg_c[p]        = (res_d != O_DIR[4*p +: 4]);
    end

    always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_DIR <= '0;
            O_CHG <= '0;
        end else begin
            O_DIR <= res_c;
            O_CHG <= chg_c;
        end
    end

endmodule

// File: tb/tb_joy_nway_arbiter.sv
// Randomised bench for joy_nway_arbiter against a window-based behavioural model,
// plus directed scenarios for latency, conflict modes, glitch rejection and rotation.
module tb_joy_nway_arbiter;

    localparam int unsigned NP      = 2;
    localparam int unsigned NB      = 4 * NP;
    localparam int unsigned DEB     = 4;
    localparam int unsigned DEB_EFF = (DEB < 1) ? 1 : DEB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] dir;
    logic          rot;
    logic [1:0]    mode;
    logic [NB-1:0] o_dir;
    logic [NP-1:0] o_chg;

    int n_vec = 0;
    int n_err = 0;

    joy_nway_arbiter #(
        .NPLAYERS   (NP),
        .DEB_CYCLES (DEB),
        .DEB_W      (8)
    ) dut (
        .clk      (clk),
        .I_RESETn (rst_n),
        .I_DIR    (dir),
        .I_ROT    (rot),
        .I_MODE   (mode),
        .O_DIR    (o_dir),
        .O_CHG    (o_chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [NB-1:0] m_s1, m_s2, m_f, m_rp, m_out;
    logic [NP-1:0] m_chg;
    logic [NB-1:0] s2_hist[$];
    int            m_lh[NP];   // 0 none, 1 R, 2 L
    int            m_lv[NP];   // 0 none, 1 D, 2 U
    bit            m_vert[NP]; // most recent press was on the vertical axis

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_f = '0; m_rp = '0; m_out = '0; m_chg = '0;
        s2_hist.delete();
        for (int p = 0; p < int'(NP); p++) begin
            m_lh[p] = 0; m_lv[p] = 0; m_vert[p] = 1'b1;
        end
    endfunction

    function automatic logic [3:0] rotate(input logic [3:0] d, input logic en);
        logic u, dn, l, r;
        {u, dn, l, r} = d;
        return en ? {l, r, dn, u} : d;
    endfunction

    function automatic logic [1:0] pick(input int who);
        return (who == 2) ? 2'b10 : (who == 1) ? 2'b01 : 2'b00;
    endfunction

    // One rising edge of the reference: outputs from pre-edge state, then advance
    function automatic void model_edge();
        logic [NB-1:0] r, nw, nf, nout;
        logic [1:0]    h, v;
        int            md;
        bit            differs;
        md = (mode == 2'b11) ? 0 : int'(mode);
        for (int p = 0; p < int'(NP); p++) r[4*p +: 4] = rotate(m_f[4*p +: 4], rot);
        nw = r & ~m_rp;
        for (int p = 0; p < int'(NP); p++) begin
            if (nw[4*p+0]) m_lh[p] = 1;
            if (nw[4*p+1]) m_lh[p] = 2;
            if (nw[4*p+2]) m_lv[p] = 1;
            if (nw[4*p+3]) m_lv[p] = 2;
            if (nw[4*p+0] || nw[4*p+1]) m_vert[p] = 1'b0;
            if (nw[4*p+2] || nw[4*p+3]) m_vert[p] = 1'b1;
            h = r[4*p +: 2];
            v = r[4*p+2 +: 2];
            if (h == 2'b11) h = (md == 1) ? 2'b00 : pick(m_lh[p]);
            if (v == 2'b11) v = (md == 1) ? 2'b00 : pick(m_lv[p]);
            if (md == 2 && h != 0 && v != 0) begin
                if (m_vert[p]) h = 2'b00;
                else           v = 2'b00;
            end
            nout[4*p +: 4] = {v, h};
            m_chg[p] = ({v, h} != m_out[4*p +: 4]);
        end
        m_rp  = r;
        m_out = nout;
        // Filtered bit flips once the last DEB_EFF synchronised samples all disagree with it
        s2_hist.push_back(m_s2);
        while (s2_hist.size() > DEB_EFF) void'(s2_hist.pop_front());
        nf = m_f;
        if (s2_hist.size() == DEB_EFF) begin
            for (int i = 0; i < int'(NB); i++) begin
                differs = 1'b1;
                foreach (s2_hist[k]) if (s2_hist[k][i] == m_f[i]) differs = 1'b0;
                if (differs) nf[i] = ~m_f[i];
            end
        end
        m_f  = nf;
        m_s2 = m_s1;
        m_s1 = dir;
    endfunction

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            check("o_dir_model", 32'(o_dir), 32'(m_out));
            check("o_chg_model", 32'(o_chg), 32'(m_chg));
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_o_dir", 32'(o_dir), 32'h0);
        check("rst_o_chg", 32'(o_chg), 32'h0);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        dir   = 8'h11;
        rot   = 1'b0;
        mode  = 2'b00;
        model_reset();

        // Held through reset: counts as a new press, 7 edges after release
        tick(3);
        check("reset_o_dir", 32'(o_dir), 32'h0);
        rst_n = 1'b1;
        tick(6);
        check("lat_before", 32'(o_dir), 32'h0);
        tick(1);
        check("lat_exact", 32'(o_dir), 32'h11);
        check("lat_chg", 32'(o_chg), 32'h3);
        tick(1);
        check("lat_chg_drop", 32'(o_chg), 32'h0);

        // Mode 00: last-wins on L/R
        dir = 8'h00; async_reset(); tick(10);
        dir = 8'h01; tick(20);
        dir = 8'h03; tick(6);
        check("m00_before", 32'(o_dir[3:0]), 32'h1);
        tick(1);
        check("m00_lwins", 32'(o_dir[3:0]), 32'h2);
        dir = 8'h01; tick(7);
        check("m00_rel", 32'(o_dir[3:0]), 32'h1);

        // Mode 01: neutral
        dir = 8'h00; mode = 2'b01; async_reset(); tick(10);
        dir = 8'h01; tick(20);
        check("m01_r", 32'(o_dir[3:0]), 32'h1);
        dir = 8'h03; tick(7);
        check("m01_both", 32'(o_dir[3:0]), 32'h0);

        // Mode 10: 4-way
        dir = 8'h00; mode = 2'b10; async_reset(); tick(10);
        dir = 8'h08; tick(10);
        check("m10_u", 32'(o_dir[3:0]), 32'h8);
        dir = 8'h09; tick(7);
        check("m10_r", 32'(o_dir[3:0]), 32'h1);
        dir = 8'h08; tick(7);
        check("m10_u_back", 32'(o_dir[3:0]), 32'h8);

        // 3-cycle glitch on P1 D is rejected
        dir = 8'h00; mode = 2'b00; async_reset(); tick(10);
        dir = 8'h40; tick(3);
        dir = 8'h00;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            check("glitch_dir", 32'(o_dir[7:4]), 32'h0);
            check("glitch_chg", 32'(o_chg[1]), 32'h0);
        end

        // Rotation, then async reset mid-hold
        rot = 1'b1;
        dir = 8'h02; tick(10);
        check("rot_l_to_u", 32'(o_dir[3:0]), 32'h8);
        async_reset();
        rot = 1'b0;

        // Randomised run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)   dir = NB'($urandom);
            else if ($urandom_range(0, 3) == 0) dir[$urandom_range(0, NB-1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0)  mode = 2'($urandom);
            if ($urandom_range(0, 149) == 0) rot = ~rot;
            if ($urandom_range(0, 999) == 0) async_reset();
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
